// File: rtl/axis_video_frame_gen.sv
// AXI4-Stream raster test-pattern source: ramp, LFSR noise, colour bars or solid fill,
// with SOF on tuser, EOL on tlast and full downstream backpressure support.
module axis_video_frame_gen #(
    parameter int          FRAME_WIDTH  = 20,
    parameter int          FRAME_HEIGHT = 10,
    parameter int          CHANNELS     = 3,
    parameter int          CH_WIDTH     = 8,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468,
    localparam int         DATA_W       = CHANNELS * CH_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] solid_color,
    output logic [DATA_W-1:0] m_axis_video_tdata,
    output logic              m_axis_video_tvalid,
    input  logic              m_axis_video_tready,
    output logic              m_axis_video_tuser,
    output logic              m_axis_video_tlast,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    localparam int XW    = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int YW    = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int BAR_W = (FRAME_WIDTH / 8 > 0) ? (FRAME_WIDTH / 8) : 1;
    localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0]  X_LAST    = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0]  Y_LAST    = YW'(FRAME_HEIGHT - 1);
    localparam logic [BCW-1:0] BC_LAST   = BCW'(BAR_W - 1);
    localparam logic [31:0]    LFSR_MASK = 32'h8020_0003;

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state_r, state_s;
    logic [XW-1:0]       x_r, x_s;
    logic [YW-1:0]       y_r, y_s;
    logic [31:0]         lfsr_r, lfsr_s;
    logic [2:0]          bar_r, bar_s;
    logic [BCW-1:0]      bar_cnt_r, bar_cnt_s;
    logic [1:0]          mode_r, mode_s;
    logic [DATA_W-1:0]   solid_r, solid_s;
    logic [15:0]         fcnt_r, fcnt_s;
    logic [DATA_W-1:0]   tdata_r, tdata_s;
    logic                tvalid_r, tvalid_s;
    logic                tuser_r, tuser_s;
    logic                tlast_r, tlast_s;
    logic                done_r, done_s;
    logic                start_s;
    logic                xfer_s;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0000_0000);
    endfunction

    function automatic logic [DATA_W-1:0] pixel(
        input logic [1:0]        m,
        input logic [XW-1:0]     px,
        input logic [YW-1:0]     py,
        input logic [CH_WIDTH-1:0] fc,
        input logic [31:0]       lf,
        input logic [2:0]        bar,
        input logic [DATA_W-1:0] solid
    );
        logic [CH_WIDTH-1:0] ch;
        logic [2:0]          pat;
        logic                pbit;
        pixel = '0;
        ch    = '0;
        pbit  = 1'b0;
        // Bar 0 maps to pattern 7 (all channels on), bar 7 to pattern 0
        pat   = 3'd7 - bar;
        case (m)
            2'd0: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    case (c)
                        0:       ch = CH_WIDTH'(px);
                        1:       ch = CH_WIDTH'(py);
                        2:       ch = fc;
                        default: ch = '0;
                    endcase
                    pixel[c*CH_WIDTH +: CH_WIDTH] = ch;
                end
            end
            2'd1: pixel = DATA_W'(lf);
            2'd2: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    case (c % 3)
                        0:       pbit = pat[0];
                        1:       pbit = pat[1];
                        default: pbit = pat[2];
                    endcase
                    pixel[c*CH_WIDTH +: CH_WIDTH] = {CH_WIDTH{pbit}};
                end
            end
            2'd3:    pixel = solid;
            default: pixel = '0;
        endcase
    endfunction

    // Next-state, raster advance and next output beat
    always_comb begin
        state_s   = state_r;
        x_s       = x_r;
        y_s       = y_r;
        lfsr_s    = lfsr_r;
        bar_s     = bar_r;
        bar_cnt_s = bar_cnt_r;
        fcnt_s    = fcnt_r;
        tvalid_s  = tvalid_r;
        done_s    = 1'b0;
        start_s   = 1'b0;
        xfer_s    = tvalid_r & m_axis_video_tready;

        case (state_r)
            IDLE: begin
                if (enable) begin
                    start_s = 1'b1;
                end else begin
                    tvalid_s = 1'b0;
                end
            end
            RUN: begin
                if (!xfer_s) begin
                    state_s = RUN;
                end else if (x_r == X_LAST && y_r == Y_LAST) begin
                    fcnt_s = fcnt_r + 16'd1;
                    done_s = 1'b1;
                    if (enable) begin
                        start_s = 1'b1;
                    end else begin
                        state_s  = IDLE;
                        tvalid_s = 1'b0;
                    end
                end else if (x_r == X_LAST) begin
                    x_s       = '0;
                    y_s       = y_r + YW'(1);
                    bar_s     = 3'd0;
                    bar_cnt_s = '0;
                    lfsr_s    = lfsr_step(lfsr_r);
                end else begin
                    x_s    = x_r + XW'(1);
                    lfsr_s = lfsr_step(lfsr_r);
                    // Bar index saturates at 7 so no divider is needed
                    if (bar_r == 3'd7) begin
                        bar_s = bar_r;
                    end else if (bar_cnt_r == BC_LAST) begin
                        bar_cnt_s = '0;
                        bar_s     = bar_r + 3'd1;
                    end else begin
                        bar_cnt_s = bar_cnt_r + BCW'(1);
                    end
                end
            end
            default: begin
                state_s  = IDLE;
                tvalid_s = 1'b0;
            end
        endcase

        if (start_s) begin
            state_s   = RUN;
            x_s       = '0;
            y_s       = '0;
            lfsr_s    = LFSR_SEED;
            bar_s     = 3'd0;
            bar_cnt_s = '0;
            mode_s    = mode;
            solid_s   = solid_color;
            tvalid_s  = 1'b1;
        end else begin
            mode_s    = mode_r;
            solid_s   = solid_r;
        end

        tuser_s = tvalid_s && (x_s == '0) && (y_s == '0);
        tlast_s = tvalid_s && (x_s == X_LAST);
        if (tvalid_s) begin
            tdata_s = pixel(mode_s, x_s, y_s, CH_WIDTH'(fcnt_s), lfsr_s, bar_s, solid_s);
        end else begin
            tdata_s = '0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            x_r       <= '0;
            y_r       <= '0;
            lfsr_r    <= LFSR_SEED;
            bar_r     <= 3'd0;
            bar_cnt_r <= '0;
            mode_r    <= 2'd0;
            solid_r   <= '0;
            fcnt_r    <= 16'd0;
            tdata_r   <= '0;
            tvalid_r  <= 1'b0;
            tuser_r   <= 1'b0;
            tlast_r   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            x_r       <= x_s;
            y_r       <= y_s;
            lfsr_r    <= lfsr_s;
            bar_r     <= bar_s;
            bar_cnt_r <= bar_cnt_s;
            mode_r    <= mode_s;
            solid_r   <= solid_s;
            fcnt_r    <= fcnt_s;
            tdata_r   <= tdata_s;
            tvalid_r  <= tvalid_s;
            tuser_r   <= tuser_s;
            tlast_r   <= tlast_s;
            done_r    <= done_s;
        end
    end

    assign m_axis_video_tdata  = tdata_r;
    assign m_axis_video_tvalid = tvalid_r;
    assign m_axis_video_tuser  = tuser_r;
    assign m_axis_video_tlast  = tlast_r;
    assign frame_done          = done_r;
    assign frame_cnt           = fcnt_r;

endmodule
